// File: rtl/bus_src_mux_reg_pkg.sv
// Shared types and default sizing for the bus source multiplexer.
// The FSM has two states: direct request service and autonomous scan.
package bus_mux_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_N_SRC  = 10;
  localparam int DEF_SEL_W  = 4;

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

endpackage

// File: rtl/bus_src_mux_reg_if.sv
// Bus-side signal bundle of the source multiplexer.
// The master modport drives requests and consumes beats; the slave modport is the mux.
interface bus_src_mux_reg_if
  import bus_mux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_SRC  = DEF_N_SRC,
  parameter int SEL_W  = DEF_SEL_W
);

  logic [N_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]        sel;
  logic                    req_valid;
  logic                    req_ready;
  logic                    scan_start;
  logic                    busy;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err;
  logic                    err_clr;

  modport master (
    output src_data, sel, req_valid, scan_start, out_ready, err_clr,
    input  req_ready, busy, out_data, out_idx, out_valid, err
  );

  modport slave (
    input  src_data, sel, req_valid, scan_start, out_ready, err_clr,
    output req_ready, busy, out_data, out_idx, out_valid, err
  );

endinterface

// File: rtl/bus_src_mux_reg_sel.sv
// Combinational indexed select over the flattened source vector.
// Indices at or beyond N_SRC yield zero and raise oor.
module bus_src_sel #(
  parameter int DATA_W = 16,
  parameter int N_SRC  = 10,
  parameter int SEL_W  = 4
) (
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]        idx,
  output logic [DATA_W-1:0]       data,
  output logic                    oor
);

  always_comb begin
    data = '0;
    oor  = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (idx == SEL_W'(i)) begin
        data = src_data[i*DATA_W +: DATA_W];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_src_mux_reg.sv
// Registered bus-source multiplexer with a one-entry output buffer,
// a sticky out-of-range flag and a scan mode that streams every source in order.
module bus_src_mux_reg
  import bus_mux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_SRC  = DEF_N_SRC,
  parameter int SEL_W  = DEF_SEL_W
) (
  input logic              clk,
  input logic              rst_n,
  bus_src_mux_reg_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SRC - 1);

  state_e            state_q;
  logic [SEL_W-1:0]  cnt_q;
  logic [DATA_W-1:0] outData_q;
  logic [SEL_W-1:0]  outIdx_q;
  logic              outValid_q;
  logic              err_q;

  logic              slotFree;
  logic              accept;
  logic              scanLoad;
  logic [SEL_W-1:0]  muxIdx;
  logic [DATA_W-1:0] selData;
  logic              selOor;

  assign slotFree      = !outValid_q || bus.out_ready;
  assign bus.req_ready = (state_q == ST_IDLE) && slotFree;
  assign accept        = bus.req_valid && bus.req_ready;
  assign scanLoad      = (state_q == ST_SCAN) && slotFree;

  // One shared selector: the scan counter owns it while scanning.
  assign muxIdx = (state_q == ST_SCAN) ? cnt_q : bus.sel;

  bus_src_sel #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC),
    .SEL_W  (SEL_W)
  ) uSel (
    .src_data (bus.src_data),
    .idx      (muxIdx),
    .data     (selData),
    .oor      (selOor)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      outData_q  <= '0;
      outIdx_q   <= '0;
      outValid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        outData_q  <= selData;
        outIdx_q   <= bus.sel;
        outValid_q <= 1'b1;
      end else if (scanLoad) begin
        outData_q  <= selData;
        outIdx_q   <= cnt_q;
        outValid_q <= 1'b1;
      end else if (bus.out_ready) begin
        outValid_q <= 1'b0;
      end

      // Setting wins over a simultaneous clear.
      if (accept && selOor) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.scan_start && !accept) begin
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scanLoad) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_idx   = outIdx_q;
  assign bus.out_valid = outValid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == ST_SCAN);

endmodule

// File: tb/tb_bus_src_mux_reg.sv
// Self-checking bench for bus_src_mux_reg: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the mux.
module tb_bus_src_mux_reg;

  localparam int DATA_W = 16;
  localparam int N_SRC  = 10;
  localparam int SEL_W  = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bus_src_mux_reg_if #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus ();

  bus_src_mux_reg #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] srcVals [N_SRC];
  int                scanQ [$];
  bit                mValid;
  logic [DATA_W-1:0] mData;
  int                mIdx;
  bit                mErr;
  int                beatIdx [$];
  int                beatData [$];
  int                total = 0;
  int                bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rv, input int s, input bit ss, input bit ordy,
                               input bit ec, input bit rn);
    bus.req_valid  = rv;
    bus.sel        = SEL_W'(s);
    bus.scan_start = ss;
    bus.out_ready  = ordy;
    bus.err_clr    = ec;
    rst_n          = rn;
    for (int i = 0; i < N_SRC; i++) bus.src_data[i*DATA_W +: DATA_W] = srcVals[i];
  endtask

  // Advance one clock: check the handshake, update the model by the spec rules, check outputs.
  task automatic stepCycle();
    bit scanning, slotFree, expReady, accept;
    int s;
    #1;
    scanning = (scanQ.size() != 0);
    slotFree = !mValid || bus.out_ready;
    expReady = !scanning && slotFree;
    checkOutput("req_ready", bus.req_ready, expReady);
    if (bus.out_valid && bus.out_ready && rst_n) begin
      beatIdx.push_back(int'(bus.out_idx));
      beatData.push_back(int'(bus.out_data));
    end
    if (!rst_n) begin
      mValid = 0; mData = '0; mIdx = 0; mErr = 0;
      scanQ.delete();
    end else begin
      s = int'(bus.sel);
      accept = bus.req_valid && expReady;
      if (accept) begin
        mData  = (s < N_SRC) ? srcVals[s] : '0;
        mIdx   = s;
        mValid = 1;
      end else if (scanning && slotFree) begin
        mIdx   = scanQ.pop_front();
        mData  = srcVals[mIdx];
        mValid = 1;
      end else if (bus.out_ready) begin
        mValid = 0;
      end
      if (accept && s >= N_SRC) mErr = 1;
      else if (bus.err_clr) mErr = 0;
      if (!scanning && bus.scan_start && !accept)
        for (int i = 0; i < N_SRC; i++) scanQ.push_back(i);
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", bus.out_valid, mValid);
    checkOutput("out_data", bus.out_data, mData);
    checkOutput("out_idx", bus.out_idx, mIdx);
    checkOutput("err", bus.err, mErr);
    checkOutput("busy", bus.busy, scanQ.size() != 0);
  endtask

  initial begin
    mValid = 0; mData = '0; mIdx = 0; mErr = 0;
    for (int i = 0; i < N_SRC; i++) srcVals[i] = DATA_W'(i * 16'h0011);
    srcVals[3] = 16'hBEEF;
    applyStimulus(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;

    // Reset with a beat pending
    applyStimulus(1, 0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("t1_pending", bus.out_valid, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    checkOutput("t1_valid", bus.out_valid, 0);
    checkOutput("t1_data", bus.out_data, 0);
    checkOutput("t1_err", bus.err, 0);
    checkOutput("t1_busy", bus.busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("t1_ready", bus.req_ready, 1);

    // Single request, one-cycle beat
    applyStimulus(1, 3, 0, 1, 0, 1);
    stepCycle();
    checkOutput("t2_valid", bus.out_valid, 1);
    checkOutput("t2_data", bus.out_data, 16'hBEEF);
    checkOutput("t2_idx", bus.out_idx, 3);
    applyStimulus(0, 0, 0, 1, 0, 1);
    stepCycle();
    checkOutput("t2_drop", bus.out_valid, 0);

    // Backpressure stall then back-to-back drain
    applyStimulus(1, 1, 0, 0, 0, 1);
    stepCycle();
    checkOutput("t3_first", bus.out_data, 16'h0011);
    applyStimulus(1, 2, 0, 0, 0, 1);
    #1;
    checkOutput("t3_stall_ready", bus.req_ready, 0);
    stepCycle();
    checkOutput("t3_hold", bus.out_data, 16'h0011);
    applyStimulus(1, 2, 0, 1, 0, 1);
    stepCycle();
    checkOutput("t3_second", bus.out_data, 16'h0022);
    checkOutput("t3_second_idx", bus.out_idx, 2);
    applyStimulus(0, 0, 0, 1, 0, 1);
    stepCycle();

    // Out-of-range select and sticky error
    applyStimulus(1, 12, 0, 1, 0, 1);
    stepCycle();
    checkOutput("t4_data", bus.out_data, 0);
    checkOutput("t4_idx", bus.out_idx, 12);
    checkOutput("t4_err", bus.err, 1);
    applyStimulus(1, 15, 0, 1, 1, 1);
    stepCycle();
    checkOutput("t4_set_wins", bus.err, 1);
    applyStimulus(0, 0, 0, 1, 1, 1);
    stepCycle();
    checkOutput("t4_clear", bus.err, 0);

    // Full-rate scan with a competing request
    for (int i = 0; i < N_SRC; i++) srcVals[i] = DATA_W'(16'h1000 + i);
    applyStimulus(0, 0, 1, 1, 0, 1);
    stepCycle();
    checkOutput("t5_busy_start", bus.busy, 1);
    applyStimulus(1, 5, 0, 1, 0, 1);
    for (int k = 0; k < N_SRC; k++) begin
      stepCycle();
      checkOutput("t5_scan_valid", bus.out_valid, 1);
      checkOutput("t5_scan_data", bus.out_data, 32'h1000 + k);
      checkOutput("t5_scan_idx", bus.out_idx, k);
      checkOutput("t5_scan_busy", bus.busy, k != N_SRC - 1);
    end
    stepCycle();
    checkOutput("t5_req_after", bus.out_idx, 5);
    applyStimulus(0, 0, 0, 1, 0, 1);
    stepCycle();

    // Scan under toggling backpressure
    beatIdx.delete();
    beatData.delete();
    applyStimulus(0, 0, 1, 1, 0, 1);
    stepCycle();
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, 0, 0, c[0], 0, 1);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 1, 0, 1);
    stepCycle();
    stepCycle();
    checkOutput("t5_beat_count", beatIdx.size(), N_SRC);
    for (int k = 0; k < N_SRC && k < beatIdx.size(); k++) begin
      checkOutput("t5_bp_idx", beatIdx[k], k);
      checkOutput("t5_bp_data", beatData[k], 32'h1000 + k);
    end

    // Reset mid-scan then restart
    applyStimulus(0, 0, 1, 1, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) stepCycle();
    checkOutput("t6_fourth", bus.out_idx, 3);
    applyStimulus(0, 0, 0, 1, 0, 0);
    stepCycle();
    checkOutput("t6_valid", bus.out_valid, 0);
    checkOutput("t6_busy", bus.busy, 0);
    applyStimulus(0, 0, 1, 1, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 1, 0, 1);
    stepCycle();
    checkOutput("t6_restart_idx", bus.out_idx, 0);
    checkOutput("t6_restart_data", bus.out_data, 16'h1000);
    for (int k = 0; k < 12; k++) stepCycle();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0)
        for (int i = 0; i < N_SRC; i++) srcVals[i] = DATA_W'($urandom);
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 49) != 0);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
